// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor: D = A - B - bin, one decimal digit per clock, LSD first.
// A start/busy/done handshake accepts one operation at a time; results hold until the next start.
module bcd_sub_serial #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   D,
    output logic                  bout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]      a_reg, b_reg;
    logic [CW-1:0]     cnt;
    logic              borrow;
    logic              last;
    logic              bad_digit;
    logic [3:0]        a_dig, b_dig, d_dig;
    logic signed [4:0] t, t_adj;
    logic              borrow_nxt;

    assign last = (cnt == LAST);

    // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // Digit mux by comparison keeps every part-select constant.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = a_reg[4*i +: 4];
                b_dig = b_reg[4*i +: 4];
            end
        end
    end

    always_comb begin
        t          = $signed({1'b0, a_dig}) - $signed({1'b0, b_dig}) - $signed({4'b0000, borrow});
        t_adj      = t + 5'sd10;
        borrow_nxt = t[4];
        d_dig      = borrow_nxt ? t_adj[3:0] : t[3:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        cnt    <= '0;
                        borrow <= bin;
                        err    <= bad_digit;
                        D      <= '0;
                    end
                end
                CALC: begin
                    cnt    <= cnt + 1'b1;
                    borrow <= borrow_nxt;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CW'(i)) D[4*i +: 4] <= d_dig;
                    end
                    if (last) begin
                        cnt <= '0;
                        // An invalid operand still runs the full loop but publishes a zero result.
                        if (err) begin
                            D    <= '0;
                            bout <= 1'b0;
                        end else begin
                            bout <= borrow_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: stimulus pushes model results, a monitor pops them on done.
// The model works on whole decimal integers rather than per-digit borrow chains.
module tb_bcd_sub_serial;

    localparam int N = 3;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, err;
    logic [W-1:0] D;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         err;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    bcd_sub_serial #(.DIGITS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        res_t r;
        int   av, bv, diff, p;
        r  = '0;
        av = 0;
        bv = 0;
        p  = 1;
        for (int i = 0; i < N; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) r.err = 1'b1;
            av += int'(a[4*i +: 4]) * p;
            bv += int'(b[4*i +: 4]) * p;
            p  *= 10;
        end
        if (r.err) return r;
        diff = av - bv - int'(bi);
        if (diff < 0) begin
            diff  += p;
            r.bout = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            r.d[4*i +: 4] = 4'(diff % 10);
            diff /= 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("done_without_pending_op", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("D", 32'(D), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bout));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    // One operation with a latency/busy-length check, a pulse-width check and an output-hold check.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int cyc, busy_cnt;
        bit seen;
        @(negedge clk);
        A = a; B = b; bin = bi; start = 1'b1;
        @(posedge clk);
        last_exp = model(a, b, bi);
        exp_q.push_back(last_exp);
        #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); bin = 1'($urandom);
        busy_cnt = 0;
        seen = 0;
        cyc = 0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(N + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("hold_D", 32'(D), 32'(last_exp.d));
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           pos, n_done;
        bit           seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_D", 32'(D), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;

        run_op(12'h835, 12'h682, 1'b0);
        run_op(12'h682, 12'h835, 1'b0);
        run_op(12'h000, 12'h000, 1'b1);
        run_op(12'h000, 12'h001, 1'b0);
        run_op(12'h451, 12'h069, 1'b0);
        run_op(12'h999, 12'h999, 1'b0);
        run_op(12'h000, 12'h999, 1'b1);
        run_op(12'h9A0, 12'h001, 1'b0);
        run_op(12'h500, 12'h001, 1'b0);
        run_op(12'h123, 12'h0F4, 1'b1);

        // Start pulsed on the first CALC edge must not disturb the running operation.
        @(negedge clk);
        A = 12'h451; B = 12'h069; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(12'h451, 12'h069, 1'b0));
        @(negedge clk);
        A = 12'h999; B = 12'h000; bin = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("midcalc_done_seen", 32'(seen), 32'd1);
        // Start during DONE is ignored as well.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        wait_drain("midcalc_drain");

        // Start held high: one operation per IDLE visit, N+2 cycles apart.
        @(negedge clk);
        A = 12'h700; B = 12'h123; bin = 1'b1; start = 1'b1;
        repeat (3) exp_q.push_back(model(12'h700, 12'h123, 1'b1));
        n_done = 0;
        for (int e = 0; e < 3 * (N + 2) - 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("held_start_ops", 32'(n_done), 32'd3);
        wait_drain("held_drain");

        // Reset on the second CALC edge aborts the operation with no done pulse.
        @(negedge clk);
        A = 12'h765; B = 12'h943; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(D), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Randomized operations, occasionally with an invalid nibble.
        for (int k = 0; k < 40; k++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 9) == 0) begin
                pos = $urandom_range(0, 2 * N - 1);
                if (pos < N) ra[4*pos +: 4] = 4'($urandom_range(10, 15));
                else         rb[4*(pos-N) +: 4] = 4'($urandom_range(10, 15));
            end
            run_op(ra, rb, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_drain("final_drain");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
- Digit-serial N-digit BCD subtractor. Computes A − B − bin on packed BCD operands, one decimal digit per clock, least significant digit first.
- It is the inverse operation of the team's 3-digit BCD adder. Its result feeds the adder so the two can be round-trip checked.
- A start/busy/done handshake fronts the datapath, so a controller FSM can issue one operation at a time.

Parameters:
- DIGITS, 3: number of BCD digits. Operand and result width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- A  in  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
- B  in  4*DIGITS  subtrahend, packed BCD.
- bin  in  1  borrow-in.
- busy  out  1  high while an operation is in progress (CALC).
- done  out  1  one-cycle pulse when D, bout and err are valid.
- D  out  4*DIGITS  packed BCD difference.
- bout  out  1  borrow-out; 1 means A < B + bin.
- err  out  1  at least one operand nibble was greater than 9.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, D=0, bout=0, err=0, digit counter=0, internal borrow=0. Reset overrides start.
- States:
  - IDLE: start=1 at an edge → latch A, B and bin into operand registers; counter=0; borrow=bin; err=(any A or B nibble >9); clear D; go to CALC; busy=1.
  - CALC: each edge processes digit i=counter:
    - t = A_i − B_i − borrow (signed, 5 bits).
    - If t<0: D_i = t+10 and borrow=1; else D_i = t and borrow=0.
    - counter increments.
    - On the edge that processes digit DIGITS−1: go to DONE; busy=0; done=1; bout=final borrow.
  - DONE: lasts one cycle; done=0 on the next edge; return to IDLE.
- Latency: start sampled at edge k → done=1 in the cycle after edge k+DIGITS. For DIGITS=3, done is high after edge k+3.
- Throughput: one operation per DIGITS+2 cycles.
- start while busy=1 or in DONE: ignored, with no side effects. Operand registers are not re-latched; changes on A/B/bin after latching have no effect.
- start held high: one operation per IDLE visit, restarting on the edge after DONE.
- Output holding: D, bout and err hold after done until the next accepted start, which clears D to 0 and recomputes err.
- Invalid digit (err=1): the digit loop still runs to full latency, but at done D=0 and bout=0 are forced, with err=1.
- Wrap-around on underflow: if A < B + bin, then D = 10^DIGITS + A − B − bin and bout=1.
  - Example: 0x000 − 0x001 gives D=0x999, bout=1.
- Result digits are always 0–9. Only the BCD digit range is valid for D; no binary carry leaks between digits.
- Reset mid-CALC: the operation is aborted, outputs take reset values on that edge, and no done pulse is produced.

Test Plan:
- A=0x835, B=0x682, bin=0 → after 4 edges: done=1, D=0x153, bout=0, err=0; busy high for exactly 3 cycles.
- A=0x682, B=0x835, bin=0 → D=0x847, bout=1.
- A=0x000, B=0x000, bin=1 → D=0x999, bout=1.
- A=0x451, B=0x069, bin=0 → D=0x382, bout=0.
- A=0x999, B=0x999, bin=0 → D=0x000, bout=0.
- A=0x9A0, B=0x001 → done=1, err=1, D=0x000, bout=0. Then a second start with A=0x500, B=0x001 → err=0, D=0x499.
- Reset and start filtering:
  - start with A=0x765, B=0x943; assert rst on the 2nd CALC edge → busy=0, done=0, D=0, and no done pulse follows.
  - Separately, pulse start again mid-CALC → it is ignored, and the first operation's result is unchanged.
